// File: rtl/sim_dma_responder.sv
// sim_dma_responder
//   Memory-side responder for the simulator DMA word interface. Stands in for
//   the host-memory model so DMA clients run unchanged in pure-RTL benches and
//   on FPGA. Each handle owns one region of on-chip RAM. Every access is
//   bounds-checked against the size recorded for that region, and read data
//   returns through a small response FIFO.
//
// Ports
//   CLK, RST                   clock, asynchronous active-high reset
//   en_init / init_*           define region: handle and size in bytes
//   en_idreturn / idreturn_id  release region
//   rdy/en_readrequest, readrequest_handle/addr
//                              read request; accepted when en && rdy
//   rdy/en_readresponse, readresponse_data
//                              head of the response FIFO; 32'haaaaaaaa when empty
//   en_write32, write32_*      byte-lane write, always accepted
//   error_count                saturating count of rejected accesses
module sim_dma_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int HANDLE_BITS = 2,
  parameter int RESP_DEPTH  = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        en_init,
  input  logic [31:0] init_handle,
  input  logic [31:0] init_size,
  input  logic        en_idreturn,
  input  logic [31:0] idreturn_id,
  output logic        rdy_readrequest,
  input  logic        en_readrequest,
  input  logic [31:0] readrequest_handle,
  input  logic [31:0] readrequest_addr,
  output logic        rdy_readresponse,
  input  logic        en_readresponse,
  output logic [31:0] readresponse_data,
  input  logic        en_write32,
  input  logic [31:0] write32_handle,
  input  logic [31:0] write32_addr,
  input  logic [31:0] write32_data,
  input  logic [3:0]  write32_byteenable,
  output logic [15:0] error_count
);

  localparam int NUM_HANDLES = 1 << HANDLE_BITS;
  localparam int MAX_WORDS   = 1 << ADDR_WIDTH;
  localparam int RAM_WORDS   = NUM_HANDLES * MAX_WORDS;
  localparam int IDX_W       = HANDLE_BITS + ADDR_WIDTH;
  localparam int PTR_W       = $clog2(RESP_DEPTH);
  localparam int CNT_W       = PTR_W + 1;
  localparam logic [31:0] EMPTY_WORD = 32'haaaaaaaa;
  localparam logic [31:0] ERROR_WORD = 32'hbbbbbbbb;

  // Region table
  logic [NUM_HANDLES-1:0] r_valid;
  logic [ADDR_WIDTH:0]    r_size [NUM_HANDLES];

  // Backing RAM and read stage
  logic [31:0]      r_mem [RAM_WORDS];
  logic [31:0]      r_rd_data;
  logic             r_inflight;
  logic             r_inflight_err;

  // Response FIFO
  logic [31:0]      r_fifo [RESP_DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  logic             r_live;
  logic [15:0]      r_err_count;

  logic [HANDLE_BITS-1:0] w_rd_hidx, w_wr_hidx;
  logic [IDX_W-1:0]       w_rd_idx, w_wr_idx;
  logic                   w_rd_legal, w_wr_legal;
  logic                   w_accept, w_rd_err, w_wr_do, w_wr_err;
  logic                   w_enq, w_deq;
  logic                   w_init_ok, w_ret_ok;
  logic [ADDR_WIDTH:0]    w_init_size;
  logic [16:0]            w_err_sum;
  logic [15:0]            w_err_next;
  logic                   w_unused;

  // NOTE: every signal driven here gets a value before any condition, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_rd_hidx  = readrequest_handle[HANDLE_BITS-1:0];
    w_wr_hidx  = write32_handle[HANDLE_BITS-1:0];
    w_rd_idx   = {w_rd_hidx, readrequest_addr[ADDR_WIDTH+1:2]};
    w_wr_idx   = {w_wr_hidx, write32_addr[ADDR_WIDTH+1:2]};
    // A handle with any bit set above the table index never matches a region.
    w_rd_legal = (readrequest_handle[31:HANDLE_BITS] == '0) && r_valid[w_rd_hidx] &&
                 ({2'b00, readrequest_addr[31:2]} < 32'(r_size[w_rd_hidx]));
    w_wr_legal = (write32_handle[31:HANDLE_BITS] == '0) && r_valid[w_wr_hidx] &&
                 ({2'b00, write32_addr[31:2]} < 32'(r_size[w_wr_hidx]));

    w_accept = en_readrequest && rdy_readrequest;
    w_rd_err = w_accept && !w_rd_legal;
    // An empty byte mask touches nothing, so it can never be an error.
    w_wr_do  = en_write32 && (write32_byteenable != 4'b0000) && w_wr_legal;
    w_wr_err = en_write32 && (write32_byteenable != 4'b0000) && !w_wr_legal;
    w_enq    = r_inflight;
    w_deq    = en_readresponse && (r_count != '0);

    w_init_ok = en_init && (init_handle[31:HANDLE_BITS] == '0);
    w_ret_ok  = en_idreturn && (idreturn_id[31:HANDLE_BITS] == '0);
    if ({2'b00, init_size[31:2]} > 32'(MAX_WORDS))
      w_init_size = (ADDR_WIDTH+1)'(MAX_WORDS);
    else
      w_init_size = init_size[ADDR_WIDTH+2:2];

    w_err_sum  = {1'b0, r_err_count} + 17'(w_rd_err) + 17'(w_wr_err);
    w_err_next = w_err_sum[16] ? 16'hffff : w_err_sum[15:0];

    w_unused = ^{init_size[1:0], readrequest_addr[1:0], write32_addr[1:0]};
  end

  // Credit comes only from registered state (FIFO occupancy plus the read in
  // flight), so a dequeue frees a slot on the following cycle.
  assign rdy_readrequest   = r_live &&
                             (({1'b0, r_count} + (CNT_W+1)'(r_inflight)) < (CNT_W+1)'(RESP_DEPTH));
  assign rdy_readresponse  = (r_count != '0);
  assign readresponse_data = (r_count != '0) ? r_fifo[r_rptr] : EMPTY_WORD;
  assign error_count       = r_err_count;

  // NOTE: sequential state uses non-blocking assignments only; when two of
  // them target the same bit at one edge, the later one in the block wins.
  // Here that makes init override a same-cycle idreturn of the same handle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_valid <= '0;
      for (int i = 0; i < NUM_HANDLES; i++) r_size[i] <= '0;
    end else begin
      if (w_ret_ok)  r_valid[idreturn_id[HANDLE_BITS-1:0]] <= 1'b0;
      if (w_init_ok) begin
        r_valid[init_handle[HANDLE_BITS-1:0]] <= 1'b1;
        r_size[init_handle[HANDLE_BITS-1:0]]  <= w_init_size;
      end
    end
  end

  // NOTE: RAM and FIFO storage have no reset. Their contents are meaningful
  // only behind valid bits and counters that are reset, so no storage
  // initialisation is needed after RST.
  // Read and write share one edge. The read samples the old word, which gives
  // read-first behaviour when both target the same address.
  always_ff @(posedge CLK) begin
    if (w_accept) r_rd_data <= r_mem[w_rd_idx];
    if (w_wr_do) begin
      for (int b = 0; b < 4; b++)
        if (write32_byteenable[b]) r_mem[w_wr_idx][8*b +: 8] <= write32_data[8*b +: 8];
    end
  end

  always_ff @(posedge CLK) begin
    if (w_enq) r_fifo[r_wptr] <= r_inflight_err ? ERROR_WORD : r_rd_data;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_live         <= 1'b0;
      r_inflight     <= 1'b0;
      r_inflight_err <= 1'b0;
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_count        <= '0;
      r_err_count    <= '0;
    end else begin
      r_live         <= 1'b1;
      r_inflight     <= w_accept;
      r_inflight_err <= w_rd_err;
      r_err_count    <= w_err_next;
      if (w_enq) r_wptr <= r_wptr + PTR_W'(1);
      if (w_deq) r_rptr <= r_rptr + PTR_W'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_sim_dma_responder.sv
// Directed testbench for sim_dma_responder (default parameters).
module tb_sim_dma_responder;

  logic        CLK = 1'b0;
  logic        RST;
  logic        en_init, en_idreturn, en_readrequest, en_readresponse, en_write32;
  logic [31:0] init_handle, init_size, idreturn_id;
  logic [31:0] readrequest_handle, readrequest_addr;
  logic [31:0] write32_handle, write32_addr, write32_data;
  logic [3:0]  write32_byteenable;
  logic        rdy_readrequest, rdy_readresponse;
  logic [31:0] readresponse_data;
  logic [15:0] error_count;

  int tests = 0;
  int fails = 0;

  sim_dma_responder dut (
    .CLK(CLK), .RST(RST),
    .en_init(en_init), .init_handle(init_handle), .init_size(init_size),
    .en_idreturn(en_idreturn), .idreturn_id(idreturn_id),
    .rdy_readrequest(rdy_readrequest), .en_readrequest(en_readrequest),
    .readrequest_handle(readrequest_handle), .readrequest_addr(readrequest_addr),
    .rdy_readresponse(rdy_readresponse), .en_readresponse(en_readresponse),
    .readresponse_data(readresponse_data),
    .en_write32(en_write32), .write32_handle(write32_handle), .write32_addr(write32_addr),
    .write32_data(write32_data), .write32_byteenable(write32_byteenable),
    .error_count(error_count)
  );

  always #5 CLK = ~CLK;

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_init(input logic [31:0] h, input logic [31:0] sz);
    en_init = 1'b1; init_handle = h; init_size = sz;
    tick();
    en_init = 1'b0;
  endtask

  task automatic do_idreturn(input logic [31:0] h);
    en_idreturn = 1'b1; idreturn_id = h;
    tick();
    en_idreturn = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] h, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be);
    en_write32 = 1'b1; write32_handle = h; write32_addr = a;
    write32_data = d; write32_byteenable = be;
    tick();
    en_write32 = 1'b0;
  endtask

  // Issue one read, wait for its response and pop it.
  task automatic read_word(input logic [31:0] h, input logic [31:0] a, output logic [31:0] d);
    int n;
    d = 32'hx;
    n = 0;
    while (!rdy_readrequest && n < 20) begin tick(); n++; end
    if (!rdy_readrequest) begin
      tests++; fails++;
      $display("FAIL read_req_timeout: rdy_readrequest=%b required 1", rdy_readrequest);
      return;
    end
    en_readrequest = 1'b1; readrequest_handle = h; readrequest_addr = a;
    tick();
    en_readrequest = 1'b0;
    n = 0;
    while (!rdy_readresponse && n < 20) begin tick(); n++; end
    if (!rdy_readresponse) begin
      tests++; fails++;
      $display("FAIL read_resp_timeout: rdy_readresponse=%b required 1", rdy_readresponse);
      return;
    end
    d = readresponse_data;
    en_readresponse = 1'b1;
    tick();
    en_readresponse = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    #1;
    tests++; if (rdy_readrequest !== 1'b0) begin fails++; $display("FAIL reset_rdy_req: got %b required 0", rdy_readrequest); end
    tests++; if (rdy_readresponse !== 1'b0) begin fails++; $display("FAIL reset_rdy_resp: got %b required 0", rdy_readresponse); end
    tests++; if (readresponse_data !== 32'haaaaaaaa) begin fails++; $display("FAIL reset_empty_data: got %h required aaaaaaaa", readresponse_data); end
    tests++; if (error_count !== 16'h0) begin fails++; $display("FAIL reset_err: got %h required 0000", error_count); end
    tick(); tick();
    tests++; if (rdy_readrequest !== 1'b0) begin fails++; $display("FAIL reset_hold_rdy_req: got %b required 0", rdy_readrequest); end
    RST = 1'b0;
    tick();
    tests++; if (rdy_readrequest !== 1'b1) begin fails++; $display("FAIL post_reset_rdy_req: got %b required 1", rdy_readrequest); end
  endtask

  task automatic test_basic();
    do_init(32'd1, 32'd64);
    do_write(32'd1, 32'd8, 32'hdeadbeef, 4'hf);
    en_readrequest = 1'b1; readrequest_handle = 32'd1; readrequest_addr = 32'd8;
    tick();  // accept edge
    en_readrequest = 1'b0;
    tests++; if (rdy_readresponse !== 1'b0) begin fails++; $display("FAIL basic_inflight: rdy_readresponse=%b required 0", rdy_readresponse); end
    tick();  // data enters FIFO
    tests++; if (rdy_readresponse !== 1'b1) begin fails++; $display("FAIL basic_latency: rdy_readresponse=%b required 1", rdy_readresponse); end
    tests++; if (readresponse_data !== 32'hdeadbeef) begin fails++; $display("FAIL basic_data: got %h required deadbeef", readresponse_data); end
    en_readresponse = 1'b1;
    tick();
    en_readresponse = 1'b0;
    tests++; if (rdy_readresponse !== 1'b0) begin fails++; $display("FAIL basic_drained: rdy_readresponse=%b required 0", rdy_readresponse); end
    tests++; if (error_count !== 16'd0) begin fails++; $display("FAIL basic_err: got %0d required 0", error_count); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] d;
    do_write(32'd1, 32'd8, 32'h11223344, 4'b0101);
    read_word(32'd1, 32'd8, d);
    tests++; if (d !== 32'hde22be44) begin fails++; $display("FAIL byte_lanes: got %h required de22be44", d); end
  endtask

  task automatic test_errors();
    logic [31:0] d;
    // Two illegal reads back to back: out of range, then never-defined handle.
    en_readrequest = 1'b1; readrequest_handle = 32'd1; readrequest_addr = 32'd64;
    tick();
    readrequest_handle = 32'd3; readrequest_addr = 32'd0;
    tick();
    en_readrequest = 1'b0;
    tick();
    tests++; if (readresponse_data !== 32'hbbbbbbbb) begin fails++; $display("FAIL err_resp0: got %h required bbbbbbbb", readresponse_data); end
    en_readresponse = 1'b1;
    tick();
    tests++; if (readresponse_data !== 32'hbbbbbbbb) begin fails++; $display("FAIL err_resp1: got %h required bbbbbbbb", readresponse_data); end
    tick();
    en_readresponse = 1'b0;
    tests++; if (rdy_readresponse !== 1'b0) begin fails++; $display("FAIL err_drained: rdy_readresponse=%b required 0", rdy_readresponse); end
    tests++; if (error_count !== 16'd2) begin fails++; $display("FAIL err_count2: got %0d required 2", error_count); end
    // Last word of the region is legal.
    do_write(32'd1, 32'd60, 32'hcafef00d, 4'hf);
    read_word(32'd1, 32'd60, d);
    tests++; if (d !== 32'hcafef00d) begin fails++; $display("FAIL last_word: got %h required cafef00d", d); end
    do_idreturn(32'd1);
    read_word(32'd1, 32'd8, d);
    tests++; if (d !== 32'hbbbbbbbb) begin fails++; $display("FAIL released_read: got %h required bbbbbbbb", d); end
    tests++; if (error_count !== 16'd3) begin fails++; $display("FAIL err_count3: got %0d required 3", error_count); end
  endtask

  task automatic test_write_errors();
    do_write(32'd3, 32'd0, 32'h1, 4'h0);
    tests++; if (error_count !== 16'd3) begin fails++; $display("FAIL be0_no_error: got %0d required 3", error_count); end
    do_write(32'd3, 32'd0, 32'h1, 4'hf);
    tests++; if (error_count !== 16'd4) begin fails++; $display("FAIL wr_error: got %0d required 4", error_count); end
    // Read error and write error on the same edge count twice.
    en_readrequest = 1'b1; readrequest_handle = 32'd3; readrequest_addr = 32'd0;
    en_write32 = 1'b1; write32_handle = 32'd3; write32_addr = 32'd4;
    write32_data = 32'h2; write32_byteenable = 4'hf;
    tick();
    en_readrequest = 1'b0; en_write32 = 1'b0;
    tests++; if (error_count !== 16'd6) begin fails++; $display("FAIL dual_error: got %0d required 6", error_count); end
    tick();
    tests++; if (readresponse_data !== 32'hbbbbbbbb) begin fails++; $display("FAIL dual_error_resp: got %h required bbbbbbbb", readresponse_data); end
    en_readresponse = 1'b1;
    tick();
    en_readresponse = 1'b0;
  endtask

  task automatic test_boundary();
    logic [31:0] d;
    do_init(32'd2, 32'hffffffff);  // clamps to 1024 words
    do_write(32'd2, 32'd4092, 32'h12345678, 4'hf);
    read_word(32'd2, 32'd4092, d);
    tests++; if (d !== 32'h12345678) begin fails++; $display("FAIL clamp_top_word: got %h required 12345678", d); end
    do_write(32'd2, 32'd4096, 32'h0, 4'hf);
    tests++; if (error_count !== 16'd7) begin fails++; $display("FAIL clamp_past_end: got %0d required 7", error_count); end
    read_word(32'h6, 32'd4092, d);  // low bits name handle 2, upper bit set
    tests++; if (d !== 32'hbbbbbbbb) begin fails++; $display("FAIL wide_handle: got %h required bbbbbbbb", d); end
    // init and idreturn of the same handle together: init wins.
    en_init = 1'b1; init_handle = 32'd2; init_size = 32'd8;
    en_idreturn = 1'b1; idreturn_id = 32'd2;
    tick();
    en_init = 1'b0; en_idreturn = 1'b0;
    do_write(32'd2, 32'd4, 32'h00000077, 4'hf);
    read_word(32'd2, 32'd4, d);
    tests++; if (d !== 32'h00000077) begin fails++; $display("FAIL init_wins: got %h required 00000077", d); end
    read_word(32'd2, 32'd8, d);
    tests++; if (d !== 32'hbbbbbbbb) begin fails++; $display("FAIL small_region: got %h required bbbbbbbb", d); end
    tests++; if (error_count !== 16'd9) begin fails++; $display("FAIL err_count9: got %0d required 9", error_count); end
  endtask

  task automatic test_back_to_back();
    int  acc;
    logic was_rdy;
    do_init(32'd1, 32'd64);
    for (int i = 0; i < 4; i++) do_write(32'd1, 32'(4*i), 32'ha0000000 + 32'(i), 4'hf);
    acc = 0;
    en_readrequest = 1'b1; readrequest_handle = 32'd1;
    for (int i = 0; i < 8; i++) begin
      readrequest_addr = 32'(4*acc);
      was_rdy = rdy_readrequest;
      tick();
      if (was_rdy) acc++;
    end
    en_readrequest = 1'b0;
    tests++; if (acc !== 4) begin fails++; $display("FAIL b2b_accepted: got %0d required 4", acc); end
    tests++; if (rdy_readrequest !== 1'b0) begin fails++; $display("FAIL b2b_full: rdy_readrequest=%b required 0", rdy_readrequest); end
    tests++; if (readresponse_data !== 32'ha0000000) begin fails++; $display("FAIL b2b_data0: got %h required a0000000", readresponse_data); end
    en_readresponse = 1'b1;
    tick();
    en_readresponse = 1'b0;
    tests++; if (rdy_readrequest !== 1'b1) begin fails++; $display("FAIL b2b_credit: rdy_readrequest=%b required 1", rdy_readrequest); end
    for (int i = 1; i < 4; i++) begin
      tests++;
      if (readresponse_data !== 32'ha0000000 + 32'(i)) begin
        fails++; $display("FAIL b2b_data%0d: got %h required %h", i, readresponse_data, 32'ha0000000 + 32'(i));
      end
      en_readresponse = 1'b1;
      tick();
      en_readresponse = 1'b0;
    end
    tests++; if (rdy_readresponse !== 1'b0) begin fails++; $display("FAIL b2b_drained: rdy_readresponse=%b required 0", rdy_readresponse); end
  endtask

  task automatic test_same_cycle();
    logic [31:0] d;
    do_write(32'd1, 32'd0, 32'h7, 4'hf);
    en_write32 = 1'b1; write32_handle = 32'd1; write32_addr = 32'd0;
    write32_data = 32'h5; write32_byteenable = 4'hf;
    en_readrequest = 1'b1; readrequest_handle = 32'd1; readrequest_addr = 32'd0;
    tick();
    en_write32 = 1'b0; en_readrequest = 1'b0;
    tick();
    tests++; if (readresponse_data !== 32'h7) begin fails++; $display("FAIL read_first: got %h required 00000007", readresponse_data); end
    en_readresponse = 1'b1;
    tick();
    en_readresponse = 1'b0;
    read_word(32'd1, 32'd0, d);
    tests++; if (d !== 32'h5) begin fails++; $display("FAIL after_write: got %h required 00000005", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic        spurious;
    en_readrequest = 1'b1; readrequest_handle = 32'd1;
    for (int i = 0; i < 3; i++) begin
      readrequest_addr = 32'(4*i);
      tick();
    end
    en_readrequest = 1'b0;
    tick();
    tests++; if (rdy_readresponse !== 1'b1) begin fails++; $display("FAIL mid_queued: rdy_readresponse=%b required 1", rdy_readresponse); end
    #2 RST = 1'b1;
    #1;
    tests++; if (rdy_readresponse !== 1'b0) begin fails++; $display("FAIL mid_rst_resp: rdy_readresponse=%b required 0", rdy_readresponse); end
    tests++; if (error_count !== 16'd0) begin fails++; $display("FAIL mid_rst_err: got %0d required 0", error_count); end
    tests++; if (readresponse_data !== 32'haaaaaaaa) begin fails++; $display("FAIL mid_rst_data: got %h required aaaaaaaa", readresponse_data); end
    tests++; if (rdy_readrequest !== 1'b0) begin fails++; $display("FAIL mid_rst_req: rdy_readrequest=%b required 0", rdy_readrequest); end
    tick(); tick();
    RST = 1'b0;
    spurious = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rdy_readresponse !== 1'b0) spurious = 1'b1;
    end
    tests++; if (spurious !== 1'b0) begin fails++; $display("FAIL mid_rst_spurious: response seen=%b required 0", spurious); end
    read_word(32'd1, 32'd0, d);
    tests++; if (d !== 32'hbbbbbbbb) begin fails++; $display("FAIL mid_rst_table: got %h required bbbbbbbb", d); end
    tests++; if (error_count !== 16'd1) begin fails++; $display("FAIL mid_rst_err_after: got %0d required 1", error_count); end
  endtask

  initial begin
    en_init = 1'b0; en_idreturn = 1'b0; en_readrequest = 1'b0;
    en_readresponse = 1'b0; en_write32 = 1'b0;
    init_handle = '0; init_size = '0; idreturn_id = '0;
    readrequest_handle = '0; readrequest_addr = '0;
    write32_handle = '0; write32_addr = '0; write32_data = '0; write32_byteenable = '0;
    test_reset();
    test_basic();
    test_byte_lanes();
    test_errors();
    test_write_errors();
    test_boundary();
    test_back_to_back();
    test_same_cycle();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sim_dma_responder.md
Name: sim_dma_responder

Overview:
- Synthesizable memory-side responder for the simulator DMA word interface (init/idreturn, readrequest/readresponse, write32).
- Replaces the DPI-backed host memory, so DMA clients run unchanged in pure-RTL benches and on FPGA.
- Serves per-handle regions from on-chip RAM, with bounds checking and a buffered response path.

Parameters:
- ADDR_WIDTH, 10: log2 words per handle region.
- HANDLE_BITS, 2: log2 handle count; NUM_HANDLES = 2^HANDLE_BITS.
- RESP_DEPTH, 4: read-response FIFO depth (power of 2, >=2).

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous, active-high reset
- en_init  in  1  define region
- init_handle  in  32  handle to define
- init_size  in  32  region size in bytes
- en_idreturn  in  1  release region
- idreturn_id  in  32  handle to release
- rdy_readrequest  out  1  request can be accepted
- en_readrequest  in  1  read request strobe
- readrequest_handle  in  32  handle
- readrequest_addr  in  32  byte address
- rdy_readresponse  out  1  response FIFO non-empty
- en_readresponse  in  1  dequeue response
- readresponse_data  out  32  head of response FIFO
- en_write32  in  1  write strobe, always accepted
- write32_handle  in  32  handle
- write32_addr  in  32  byte address
- write32_data  in  32  data
- write32_byteenable  in  4  byte lanes
- error_count  out  16  saturating count of rejected accesses

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - all region valid bits 0, sizes 0, FIFO empty, in-flight 0, error_count 0.
  - rdy_readrequest=0 while RST high, 1 on first cycle after.
  - rdy_readresponse=0; readresponse_data=32'haaaaaaaa when empty.
  - RAM contents not cleared.
- Region table, per handle h: valid, size_words = min(init_size>>2, 2^ADDR_WIDTH).
  - en_init sets valid and size. en_idreturn clears valid.
  - Both on the same handle in the same cycle: init wins.
  - Handles with bits above HANDLE_BITS nonzero are invalid.
  - Table update visible to requests from the next cycle.
- Access legal iff handle valid and (addr>>2) < size_words. addr[1:0] ignored.
  - RAM index = {handle[HANDLE_BITS-1:0], addr[ADDR_WIDTH+1:2]}.
- Write:
  - Legal write updates enabled byte lanes at the clock edge.
  - byteenable=0: no-op, not an error.
  - Illegal write is dropped and error_count increments.
- Read pipeline:
  - Request accepted when en_readrequest && rdy_readrequest.
  - RAM read in the accept cycle; data enters FIFO next edge, so rdy_readresponse rises 1 cycle after accept (latency 1).
  - Illegal read enqueues 32'hbbbbbbbb, increments error_count, and preserves ordering.
  - Read and write to the same word in the same cycle: read returns pre-write data (read-first).
- Flow control:
  - rdy_readrequest = (fifo_count + inflight) < RESP_DEPTH; registered credit, no combinational path from en_readresponse.
  - en_readrequest while rdy_readrequest=0: ignored.
  - en_readresponse while empty: ignored.
  - Simultaneous enqueue and dequeue: count unchanged; FIFO ordering strict.
- FIFO pointers wrap modulo RESP_DEPTH.
- error_count saturates at 16'hffff. Read error and write error in the same cycle add 2 (saturating).
- Reset mid-operation: in-flight reads and queued responses are discarded; no response emitted after RST.

Test Plan:
- Init handle 1, size 64. Write32 addr 8 data 32'hdeadbeef be 4'hf, then read addr 8 -> response 32'hdeadbeef one cycle after accept; error_count=0.
- Write addr 8 data 32'h11223344 be 4'b0101 over 32'hdeadbeef, then read -> 32'hde22be44.
- Read handle 1 addr 64 (== size) and handle 3 (never inited) -> two responses 32'hbbbbbbbb in order; error_count=2. Same for idreturn'd handle 1 -> 32'hbbbbbbbb.
- Issue reads back-to-back with en_readresponse=0 -> exactly RESP_DEPTH=4 accepted, rdy_readrequest=0. Dequeue one -> rdy_readrequest returns next cycle. Data order matches addresses 0,4,8,12.
- Same-cycle write 32'h5 and read to addr 0 holding 32'h7 -> response 32'h7; subsequent read -> 32'h5.
- Assert RST asynchronously with 3 responses queued -> rdy_readresponse=0 immediately, error_count=0, region table invalid, no spurious response after release.
